// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads and
// pushes returned words into the downstream two-entry queue, squashing on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        deq,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] instr_out,
    output logic        enqueue,
    output logic [31:0] pc_out,
    output logic        flush
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [2:0] DEPTH = 3'(QUEUE_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [2:0]  slots_q, slots_d;
    logic        enq_q, enq_d;
    logic        flush_q, flush_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;

    logic        in_flight_s;
    logic        issue_s;
    logic        deq_ok_s;
    logic        drain_done_s;

    // Issue / slot bookkeeping qualifiers; slots also count the in-flight reservation
    always_comb begin
        in_flight_s  = (state_q == WAIT) || (state_q == DRAIN);
        issue_s      = rst_n && (state_q == IDLE) && (slots_q < DEPTH) && !branch_valid;
        drain_done_s = (state_q == DRAIN) && imem_rvalid;
        deq_ok_s     = deq && !branch_valid && (slots_q != 3'd0)
                       && !((slots_q == 3'd1) && in_flight_s);
    end

    // Next-state logic: redirect has priority over every state transition
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        slots_d  = slots_q;
        enq_d    = 1'b0;
        flush_d  = 1'b0;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        if (branch_valid) begin
            pc_d    = branch_target & ~32'h0000_0003;
            flush_d = 1'b1;
            // A response still owed by memory keeps its slot until it drains
            if (in_flight_s && !imem_rvalid) begin
                slots_d = 3'd1;
                state_d = DRAIN;
            end else begin
                slots_d = 3'd0;
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_s) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = WAIT;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        enq_d    = 1'b1;
                        instr_d  = imem_rdata;
                        pc_out_d = req_pc_q;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            slots_d = slots_q + {2'b00, issue_s} - {2'b00, drain_done_s} - {2'b00, deq_ok_s};
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0000_0000;
            slots_q  <= 3'd0;
            enq_q    <= 1'b0;
            flush_q  <= 1'b0;
            instr_q  <= 32'h0000_0000;
            pc_out_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            slots_q  <= slots_d;
            enq_q    <= enq_d;
            flush_q  <= flush_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign imem_req  = issue_s;
    assign imem_addr = pc_q;
    assign enqueue   = enq_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
    assign flush     = flush_q;

endmodule
